// File: rtl/bp_me_lce_cmd_burst_arbiter_if.sv
// LCE command burst bus between the requesters, the arbiter and the downstream channel.
// Signal names follow the arbiter's point of view; the arbiter uses the slave modport.
interface bp_me_lce_cmd_burst_arbiter_if #(
  parameter int unsigned num_req_p      = 2,
  parameter int unsigned header_width_p = 128,
  parameter int unsigned data_width_p   = 64
);
  logic [num_req_p*header_width_p-1:0] hdr_i;
  logic [num_req_p-1:0]                hdr_has_data_i;
  logic [num_req_p-1:0]                hdr_v_i;
  logic [num_req_p-1:0]                hdr_ready_and_o;
  logic [num_req_p*data_width_p-1:0]   data_i;
  logic [num_req_p-1:0]                data_last_i;
  logic [num_req_p-1:0]                data_v_i;
  logic [num_req_p-1:0]                data_ready_and_o;
  logic [header_width_p-1:0]           hdr_o;
  logic                                hdr_v_o;
  logic                                hdr_ready_and_i;
  logic [data_width_p-1:0]             data_o;
  logic                                data_v_o;
  logic                                data_ready_and_i;

  modport slave (
    input  hdr_i, hdr_has_data_i, hdr_v_i, data_i, data_last_i, data_v_i,
    input  hdr_ready_and_i, data_ready_and_i,
    output hdr_ready_and_o, data_ready_and_o, hdr_o, hdr_v_o, data_o, data_v_o
  );

  modport master (
    output hdr_i, hdr_has_data_i, hdr_v_i, data_i, data_last_i, data_v_i,
    output hdr_ready_and_i, data_ready_and_i,
    input  hdr_ready_and_o, data_ready_and_o, hdr_o, hdr_v_o, data_o, data_v_o
  );
endinterface

// File: rtl/bp_me_lce_cmd_burst_arbiter.sv
// Round-robin arbiter for the CCE outbound LCE command burst channel; grant locked per burst.
// Optional per-requester header counters enabled by BP_ME_CMD_ARB_GRANT_CNT_EN.
module bp_me_lce_cmd_burst_arbiter #(
  parameter int unsigned num_req_p      = 2,
  parameter int unsigned header_width_p = 128,
  parameter int unsigned data_width_p   = 64
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  bp_me_lce_cmd_burst_arbiter_if.slave  bus,
  output logic [num_req_p-1:0]          grant_o,
  output logic [num_req_p*32-1:0]       grant_cnt_o
);

  localparam int unsigned IdxW = $clog2(num_req_p);

  typedef enum logic [1:0] {StIdle, StHold, StData} state_e;

  state_e                state_q, state_d;
  logic [IdxW-1:0]       owner_q, owner_d;
  logic [IdxW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]       cand, pick_idx, sel_idx;
  logic                  pick_v, hdr_v, hdr_hs, data_hs;
  logic [num_req_p-1:0]  sel_oh;

  function automatic logic [IdxW-1:0] inc_idx(input logic [IdxW-1:0] idx);
    return (32'(idx) == num_req_p - 1) ? '0 : idx + IdxW'(1);
  endfunction

  // First valid header at or after rr_ptr, wrapping.
  always_comb begin
    pick_v   = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int unsigned i = 0; i < num_req_p; i++) begin
      cand = IdxW'((32'(rr_ptr_q) + i) % num_req_p);
      if (!pick_v && bus.hdr_v_i[cand]) begin
        pick_v   = 1'b1;
        pick_idx = cand;
      end
    end
  end

  always_comb begin
    state_d              = state_q;
    owner_d              = owner_q;
    rr_ptr_d             = rr_ptr_q;
    hdr_v                = 1'b0;
    hdr_hs               = 1'b0;
    data_hs              = 1'b0;
    grant_o              = '0;
    bus.hdr_o            = '0;
    bus.hdr_v_o          = 1'b0;
    bus.hdr_ready_and_o  = '0;
    bus.data_o           = '0;
    bus.data_v_o         = 1'b0;
    bus.data_ready_and_o = '0;
    sel_idx              = (state_q == StIdle) ? pick_idx : owner_q;
    sel_oh               = '0;
    sel_oh[sel_idx]      = 1'b1;

    unique case (state_q)
      StIdle, StHold: begin
        // HOLD keeps the latched source so a pending header never switches.
        if (state_q == StHold || pick_v) begin
          grant_o             = sel_oh;
          hdr_v               = bus.hdr_v_i[sel_idx];
          bus.hdr_o           = bus.hdr_i[32'(sel_idx)*header_width_p +: header_width_p];
          bus.hdr_v_o         = hdr_v;
          bus.hdr_ready_and_o = bus.hdr_ready_and_i ? sel_oh : '0;
          hdr_hs              = hdr_v && bus.hdr_ready_and_i;
          if (hdr_hs) begin
            if (bus.hdr_has_data_i[sel_idx]) begin
              state_d = StData;
              owner_d = sel_idx;
            end else begin
              state_d  = StIdle;
              rr_ptr_d = inc_idx(sel_idx);
            end
          end else if (hdr_v) begin
            state_d = StHold;
            owner_d = sel_idx;
          end
        end
      end
      StData: begin
        grant_o              = sel_oh;
        bus.data_o           = bus.data_i[32'(owner_q)*data_width_p +: data_width_p];
        bus.data_v_o         = bus.data_v_i[owner_q];
        bus.data_ready_and_o = bus.data_ready_and_i ? sel_oh : '0;
        data_hs              = bus.data_v_i[owner_q] && bus.data_ready_and_i;
        if (data_hs && bus.data_last_i[owner_q]) begin
          state_d  = StIdle;
          rr_ptr_d = inc_idx(owner_q);
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs are forced quiet for the whole time reset is held.
    if (!reset_i) begin
      grant_o              = '0;
      bus.hdr_o            = '0;
      bus.hdr_v_o          = 1'b0;
      bus.hdr_ready_and_o  = '0;
      bus.data_o           = '0;
      bus.data_v_o         = 1'b0;
      bus.data_ready_and_o = '0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q  <= StIdle;
      owner_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

`ifdef BP_ME_CMD_ARB_GRANT_CNT_EN
  logic [num_req_p-1:0][31:0] cnt_q;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      cnt_q <= '0;
    end else begin
      for (int unsigned i = 0; i < num_req_p; i++) begin
        if (bus.hdr_ready_and_o[i] && bus.hdr_v_i[i] && cnt_q[i] != 32'hFFFF_FFFF) begin
          cnt_q[i] <= cnt_q[i] + 32'd1;
        end
      end
    end
  end

  assign grant_cnt_o = cnt_q;
`else
  assign grant_cnt_o = '0;
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (reset_i && state_q == StHold) begin
      assert (bus.hdr_v_i[owner_q])
        else $error("held owner dropped hdr_v_i before acceptance");
    end
  end
`endif

endmodule
